// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory,
// with a sweep engine that zeroes every word on request.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned ADDR_WIDTH        = 10,
  parameter int unsigned NUMBER_OF_ELEMETS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ready,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ready,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUMBER_OF_ELEMETS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_done_q, clr_done_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  gnt0, gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // prio_q == 0 prefers r0; a grant hands preference to the other requester
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        // No grants while reset is held, since the async reset keeps us in IDLE
        if (!rst) begin
          if (clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end else begin
            gnt0 = r0_valid && (!r1_valid || !prio_q);
            gnt1 = r1_valid && !gnt0;
            if (gnt0) begin
              mem_addr  = r0_addr;
              mem_we    = r0_we;
              mem_wdata = r0_wdata;
              prio_d    = 1'b1;
              if (!r0_we) begin
                rvalid0_d = 1'b1;
                rdata0_d  = mem_rdata;
              end
            end else if (gnt1) begin
              mem_addr  = r1_addr;
              mem_we    = r1_we;
              mem_wdata = r1_wdata;
              prio_d    = 1'b0;
              if (!r1_we) begin
                rvalid1_d = 1'b1;
                rdata1_d  = mem_rdata;
              end
            end
          end
        end
      end
      CLEAR: begin
        mem_addr = cnt_q;
        mem_we   = 1'b1;
        cnt_d    = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign r0_ready  = gnt0;
  assign r1_ready  = gnt1;
  assign r0_rvalid = rvalid0_q;
  assign r1_rvalid = rvalid1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign clr_busy  = (state_q == CLEAR);
  assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration, read latency, clear sweep,
// reset during a sweep and clear re-trigger, against a behavioural memory.
module tb_mem_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int          N  = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_valid, r0_we, r0_ready, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_we, r1_ready, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          clr_start, clr_busy, clr_done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:N-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUMBER_OF_ELEMETS(N)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model; 0xEE stands in for the floating bus during writes
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_we ? 8'hEE : mem[mem_addr];

  task automatic set_r0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask

  task automatic set_r1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_r0(1'b0, 1'b0, '0, '0); set_r1(1'b0, 1'b0, '0, '0); clr_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_r0(1'b1, 1'b1, 10'd3, 8'h33); set_r1(1'b1, 1'b0, 10'd4, 8'h00); clr_start = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({r0_ready, r1_ready, mem_we, clr_busy, clr_done, r0_rvalid, r1_rvalid} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000",
                      {r0_ready, r1_ready, mem_we, clr_busy, clr_done, r0_rvalid, r1_rvalid});
    end
    total++;
    if ({r0_rdata, r1_rdata} !== 16'h0000) begin
      bad++; $display("FAIL reset_rdata: got %h want 0000", {r0_rdata, r1_rdata});
    end
    @(negedge clk);
    set_r0(1'b0, 1'b0, '0, '0); set_r1(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk); set_r0(1'b1, 1'b1, 10'd5, 8'hA5); #1;
    total++;
    if ({r0_ready, r1_ready, mem_we, mem_addr, mem_wdata} !== {3'b101, 10'd5, 8'hA5}) begin
      bad++; $display("FAIL wr_grant: got rdy0=%b rdy1=%b we=%b a=%0d d=%h want 1 0 1 5 a5",
                      r0_ready, r1_ready, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk); set_r0(1'b1, 1'b0, 10'd5, 8'h00); #1;
    total++;
    if ({r0_ready, mem_we, r0_rvalid} !== 3'b100) begin
      bad++; $display("FAIL rd_grant: got rdy0=%b we=%b rvalid0=%b want 1 0 0", r0_ready, mem_we, r0_rvalid);
    end
    @(negedge clk);
    total++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 8'hA5) begin
      bad++; $display("FAIL rd_data: got rvalid=%b data=%h want 1 a5", r0_rvalid, r0_rdata);
    end
    set_r0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (r0_rvalid !== 1'b0 || r0_rdata !== 8'hA5 || r1_rvalid !== 1'b0) begin
      bad++; $display("FAIL rd_hold: got rvalid0=%b data=%h rvalid1=%b want 0 a5 0", r0_rvalid, r0_rdata, r1_rvalid);
    end
  endtask

  task automatic test_idle_bus();
    @(negedge clk); #1;
    total++;
    if ({mem_we, mem_addr, mem_wdata, r0_ready, r1_ready} !== '0) begin
      bad++; $display("FAIL idle_bus: got we=%b a=%0d d=%h rdy=%b%b want all 0",
                      mem_we, mem_addr, mem_wdata, r0_ready, r1_ready);
    end
  endtask

  task automatic test_round_robin();
    logic e0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_r0(1'b1, 1'b0, 10'd5, 8'h00); set_r1(1'b1, 1'b1, 10'd6, 8'(8'h10 + i)); #1;
      e0 = ((i % 2) == 0);
      total++;
      if (r0_ready !== e0 || r1_ready !== !e0 || mem_addr !== (e0 ? 10'd5 : 10'd6)) begin
        bad++; $display("FAIL rr_grant%0d: got rdy0=%b rdy1=%b a=%0d want %b %b %0d",
                        i, r0_ready, r1_ready, mem_addr, e0, !e0, e0 ? 5 : 6);
      end
      total++;
      if (r0_rvalid !== !e0) begin
        bad++; $display("FAIL rr_rvalid%0d: got %b want %b", i, r0_rvalid, !e0);
      end
    end
  endtask

  task automatic test_lone_r1();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_r0(1'b0, 1'b0, '0, '0); set_r1(1'b1, 1'b0, 10'd6, 8'h00); #1;
      total++;
      if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
        bad++; $display("FAIL lone_r1_%0d: got rdy0=%b rdy1=%b want 0 1", i, r0_ready, r1_ready);
      end
    end
    @(negedge clk);
    set_r0(1'b1, 1'b0, 10'd5, 8'h00); set_r1(1'b1, 1'b0, 10'd6, 8'h00); #1;
    total++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      bad++; $display("FAIL after_lone: got rdy0=%b rdy1=%b want 1 0", r0_ready, r1_ready);
    end
    total++;
    if (r1_rvalid !== 1'b1 || r1_rdata !== 8'h13) begin
      bad++; $display("FAIL lone_rdata: got rvalid1=%b data=%h want 1 13", r1_rvalid, r1_rdata);
    end
    @(negedge clk);
    set_r0(1'b0, 1'b0, '0, '0); set_r1(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_clear();
    int busy = 0, done = 0, rdy = 0, addr_err = 0, late = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_r0(1'b1, 1'b1, AW'(i), 8'hFF);
    end
    @(negedge clk);
    set_r0(1'b1, 1'b0, 10'd0, 8'h00); clr_start = 1'b1; #1;
    total++;
    if (r0_ready !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL clr_start_cycle: got rdy0=%b we=%b want 0 0", r0_ready, mem_we);
    end
    for (int i = 1; i <= 1030; i++) begin
      @(negedge clk);
      if (clr_busy) begin
        if (mem_addr !== busy[AW-1:0] || mem_we !== 1'b1 || mem_wdata !== 8'h00) addr_err++;
        if (r0_ready) rdy++;
        busy++;
      end
      if (clr_done) begin
        done++;
        if (clr_busy || busy != N) late++;
      end
      if (i == 1) clr_start = 1'b0;
    end
    total++;
    if (busy != N || done != 1) begin
      bad++; $display("FAIL clr_len: got busy=%0d done=%0d want %0d 1", busy, done, N);
    end
    total++;
    if (rdy != 0 || addr_err != 0 || late != 0) begin
      bad++; $display("FAIL clr_sweep: got rdy=%0d addr_err=%0d late_done=%0d want 0 0 0", rdy, addr_err, late);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_r0(1'b1, 1'b0, AW'(i), 8'h00);
      @(negedge clk); set_r0(1'b0, 1'b0, '0, '0);
      total++;
      if (r0_rvalid !== 1'b1 || r0_rdata !== 8'h00) begin
        bad++; $display("FAIL clr_read%0d: got rvalid=%b data=%h want 1 00", i, r0_rvalid, r0_rdata);
      end
    end
  endtask

  task automatic test_rst_mid_clear();
    int busy = 0;
    @(negedge clk); set_r0(1'b1, 1'b1, 10'd20, 8'h5C);
    @(negedge clk); set_r0(1'b1, 1'b1, 10'd8, 8'h88);
    @(negedge clk); set_r0(1'b0, 1'b0, '0, '0); clr_start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) clr_start = 1'b0;
      if (clr_busy) busy++;
    end
    rst = 1'b1; #1;
    total++;
    if (busy != 10 || clr_busy !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL rst_abort: got busy_cycles=%0d busy=%b we=%b want 10 0 0", busy, clr_busy, mem_we);
    end
    @(negedge clk);
    total++;
    if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
      bad++; $display("FAIL rst_no_done: got done=%b busy=%b want 0 0", clr_done, clr_busy);
    end
    rst = 1'b0;
    set_r0(1'b1, 1'b0, 10'd20, 8'h00); set_r1(1'b1, 1'b0, 10'd8, 8'h00); #1;
    total++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      bad++; $display("FAIL rst_serve0: got rdy0=%b rdy1=%b want 1 0", r0_ready, r1_ready);
    end
    @(negedge clk);
    total++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 8'h5C || r1_ready !== 1'b1 || clr_done !== 1'b0) begin
      bad++; $display("FAIL rst_retain: got rvalid0=%b data=%h rdy1=%b done=%b want 1 5c 1 0",
                      r0_rvalid, r0_rdata, r1_ready, clr_done);
    end
    @(negedge clk);
    set_r0(1'b0, 1'b0, '0, '0); set_r1(1'b0, 1'b0, '0, '0);
    total++;
    if (r1_rvalid !== 1'b1 || r1_rdata !== 8'h00) begin
      bad++; $display("FAIL rst_cleared8: got rvalid1=%b data=%h want 1 00", r1_rvalid, r1_rdata);
    end
  endtask

  task automatic test_repulse();
    int busy = 0, done = 0;
    @(negedge clk); set_r0(1'b1, 1'b1, 10'd30, 8'h30);
    @(negedge clk); set_r0(1'b0, 1'b0, '0, '0); clr_start = 1'b1;
    for (int i = 1; i <= 1030; i++) begin
      @(negedge clk);
      clr_start = (i == 500);
      if (clr_busy) busy++;
      if (clr_done) done++;
    end
    clr_start = 1'b0;
    total++;
    if (busy != N || done != 1) begin
      bad++; $display("FAIL repulse_len: got busy=%0d done=%0d want %0d 1", busy, done, N);
    end
    @(negedge clk);
    set_r0(1'b1, 1'b0, 10'd1, 8'h00); set_r1(1'b1, 1'b0, 10'd2, 8'h00); #1;
    total++;
    if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
      bad++; $display("FAIL prio_kept: got rdy0=%b rdy1=%b want 0 1", r0_ready, r1_ready);
    end
    @(negedge clk);
    set_r0(1'b0, 1'b0, '0, '0); set_r1(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_idle_bus();
    test_round_robin();
    test_lone_r1();
    test_clear();
    test_rst_mid_clear();
    test_repulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, memory address width.
REQ-003 SHALL have parameter NUMBER_OF_ELEMETS, default 1024, words swept by a clear.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have ports rN_valid, input, 1, requester N (N=0,1) presents a request.
REQ-007 SHALL have ports rN_we, input, 1, request type: 1 write, 0 read.
REQ-008 SHALL have ports rN_addr, input, ADDR_WIDTH, request address.
REQ-009 SHALL have ports rN_wdata, input, DATA_WIDTH, write data.
REQ-010 SHALL have ports rN_ready, output, 1, request accepted this cycle (combinational).
REQ-011 SHALL have ports rN_rvalid, output, 1, registered one-cycle read-data strobe.
REQ-012 SHALL have ports rN_rdata, output, DATA_WIDTH, registered read data.
REQ-013 SHALL have port clr_start, input, 1, request to zero the whole memory.
REQ-014 SHALL have port clr_busy, output, 1, high while the clear sweep runs.
REQ-015 SHALL have port clr_done, output, 1, one-cycle pulse after the final clear write.
REQ-016 SHALL have ports mem_addr, mem_we, mem_wdata, outputs (ADDR_WIDTH/1/DATA_WIDTH), driving the memory port.
REQ-017 SHALL have port mem_rdata, input, DATA_WIDTH, memory combinational read data.

Function
REQ-018 FSM states SHALL be IDLE (arbitrate requesters) and CLEAR (sweep).
REQ-019 In IDLE, at most one request SHALL be granted per cycle; the grant SHALL be combinational from rN_valid and the priority bit.
REQ-020 Arbitration SHALL be round-robin: priority bit selects the preferred requester; a lone valid requester is always granted; on any grant the priority bit SHALL switch to the other requester.
REQ-021 Granted requester's addr/we/wdata SHALL drive mem_addr/mem_we/mem_wdata in the same cycle; rN_ready SHALL be high for the grantee only.
REQ-022 With no grant, mem_we SHALL be 0, mem_addr 0, mem_wdata 0.
REQ-023 A granted write SHALL complete at that clock edge; no response is generated.
REQ-024 A granted read SHALL capture mem_rdata into rN_rdata at that edge; rN_rvalid SHALL be high exactly the following cycle (latency 1).
REQ-025 mem_rdata SHALL be sampled only for granted reads (memory drives Z during writes).
REQ-026 rN_rdata SHALL hold its value until the next read for that requester.
REQ-027 clr_start in IDLE SHALL take precedence over requests: no grant that cycle; next state CLEAR, address counter 0.
REQ-028 In CLEAR, each cycle SHALL drive mem_we=1, mem_wdata=0, mem_addr=counter, then increment; both rN_ready SHALL be 0; clr_busy SHALL be 1.
REQ-029 After the write at address NUMBER_OF_ELEMETS-1 the FSM SHALL return to IDLE and clr_done SHALL pulse for one cycle (the first IDLE cycle); a sweep thus takes exactly NUMBER_OF_ELEMETS cycles.
REQ-030 clr_start while in CLEAR SHALL be ignored; the counter SHALL not wrap or restart.
REQ-031 The priority bit SHALL be unchanged across a clear.

Reset
REQ-032 On rst assertion, asynchronously: state IDLE, priority bit selects r0, counter 0, rN_rvalid 0, rN_rdata 0, clr_done 0.
REQ-033 rst during CLEAR SHALL abort the sweep with no clr_done pulse; memory contents beyond the abort point are unchanged.
REQ-034 While rst is high, rN_ready SHALL be 0 and mem_we SHALL be 0.

Verification
REQ-035 r0 write addr 5 data 0xA5, then r0 read addr 5 -> r0_ready on both, r0_rvalid one cycle after read grant, r0_rdata=0xA5.
REQ-036 r0 and r1 valid continuously after reset -> grants r0,r1,r0,r1...; each ready once per two cycles.
REQ-037 Only r1 valid for 3 cycles -> r1 granted every cycle; afterward both valid -> r0 granted first.
REQ-038 Fill addresses 0..3 with 0xFF, pulse clr_start with r0 valid -> no r0_ready for 1024 cycles, clr_busy high 1024 cycles, clr_done single pulse, reads of 0..3 return 0x00.
REQ-039 Assert rst at clear cycle 10 -> clr_busy drops immediately, no clr_done, address 20 retains prior value, r0/r1 served next cycle after rst release.
REQ-040 clr_start re-pulsed mid-sweep -> sweep length still 1024 cycles, one clr_done.
